// File: rtl/dma_arb.sv
// -----------------------------------------------------------------------------
// dma_arb
//
// Round-robin arbiter that shares one DMA address generator among NREQ job
// requesters. The winning requester's descriptor is registered and presented
// on the DMA start handshake. The DMA output stream is tapped to track which
// requester owns the running job, and that requester's done bit pulses for
// one cycle after the job's last beat.
//
// Optional feature macro: DMA_ARB_PRIO_EN
//   defined   - requester 0 has strict priority; 1..NREQ-1 round-robin
//   undefined - pure round-robin across all NREQ requesters
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      per-requester job handshake (ready one-hot/zero)
//   req_base/size/step/info    flattened descriptors, requester i at [i*W +: W]
//   m_base/size/step/info/id   registered descriptor to the DMA
//   m_valid / m_ready          DMA start handshake
//   mon_valid/ready/last       tap of the DMA output stream
//   done                       one-cycle pulse per requester on job completion
//   busy                       job running or descriptor pending
//   run_id                     owner of the running job
// -----------------------------------------------------------------------------
module dma_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int AW   = 11,
  parameter int IFW  = 8,
  parameter int SZW  = 7,
  parameter int STW  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*AW-1:0]  req_base,
  input  logic [NREQ*SZW-1:0] req_size,
  input  logic [NREQ*STW-1:0] req_step,
  input  logic [NREQ*IFW-1:0] req_info,
  output logic [AW-1:0]       m_base,
  output logic [SZW-1:0]      m_size,
  output logic [STW-1:0]      m_step,
  output logic [IFW-1:0]      m_info,
  output logic [IDW-1:0]      m_id,
  output logic                m_valid,
  input  logic                m_ready,
  input  logic                mon_valid,
  input  logic                mon_ready,
  input  logic                mon_last,
  output logic [NREQ-1:0]     done,
  output logic                busy,
  output logic [IDW-1:0]      run_id
);

  // With priority enabled the round-robin pointer only ever covers 1..NREQ-1,
  // so it comes out of reset pointing at requester 1.
`ifdef DMA_ARB_PRIO_EN
  localparam logic [IDW-1:0] RR_RESET = IDW'(1);
`else
  localparam logic [IDW-1:0] RR_RESET = '0;
`endif

  logic [AW-1:0]   m_base_q;
  logic [SZW-1:0]  m_size_q;
  logic [STW-1:0]  m_step_q;
  logic [IFW-1:0]  m_info_q;
  logic [IDW-1:0]  m_id_q;
  logic            m_valid_q;
  logic [NREQ-1:0] done_q;
  logic [IDW-1:0]  run_id_q;
  logic            run_active_q;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic [IDW-1:0]  gnt_id;
  logic            load, grant, start, fin;

  assign load  = ~m_valid_q | m_ready;
  assign grant = load & (|req_valid);
  assign start = m_valid_q & m_ready;
  assign fin   = run_active_q & mon_valid & mon_ready & mon_last;

  // Scan from rr_ptr upward with an explicit modulo wrap; first valid wins.
  always_comb begin : arb_scan
    int idx;
    logic [IDW-1:0] cand;
    logic found;
    idx    = 0;
    cand   = '0;
    found  = 1'b0;
    gnt_id = '0;
`ifdef DMA_ARB_PRIO_EN
    if (req_valid[0]) begin
      found = 1'b1;
    end
    for (int k = 0; k < NREQ-1; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - (NREQ - 1);
      cand = IDW'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        gnt_id = cand;
      end
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        gnt_id = cand;
      end
    end
`endif
  end

  // Pointer moves just past the winner; NREQ need not be a power of two.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
`ifdef DMA_ARB_PRIO_EN
    if (gnt_id == '0)                   rr_ptr_d = rr_ptr_q;
    else if (gnt_id == IDW'(NREQ - 1))  rr_ptr_d = IDW'(1);
    else                                rr_ptr_d = gnt_id + IDW'(1);
`else
    if (gnt_id == IDW'(NREQ - 1)) rr_ptr_d = '0;
    else                          rr_ptr_d = gnt_id + IDW'(1);
`endif
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready = NREQ'(1) << gnt_id;
  end

  // fin and start may coincide: done goes to the old owner while the new
  // owner is loaded, since the DMA takes its next start on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_base_q     <= '0;
      m_size_q     <= '0;
      m_step_q     <= '0;
      m_info_q     <= '0;
      m_id_q       <= '0;
      m_valid_q    <= 1'b0;
      done_q       <= '0;
      run_id_q     <= '0;
      run_active_q <= 1'b0;
      rr_ptr_q     <= RR_RESET;
    end else begin
      done_q <= '0;
      if (fin) done_q[run_id_q] <= 1'b1;

      if (start) begin
        run_id_q     <= m_id_q;
        run_active_q <= 1'b1;
      end else if (fin) begin
        run_active_q <= 1'b0;
      end

      if (grant) begin
        m_base_q  <= req_base[int'(gnt_id)*AW +: AW];
        m_size_q  <= req_size[int'(gnt_id)*SZW +: SZW];
        m_step_q  <= req_step[int'(gnt_id)*STW +: STW];
        m_info_q  <= req_info[int'(gnt_id)*IFW +: IFW];
        m_id_q    <= gnt_id;
        m_valid_q <= 1'b1;
        rr_ptr_q  <= rr_ptr_d;
      end else if (start) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_base  = m_base_q;
  assign m_size  = m_size_q;
  assign m_step  = m_step_q;
  assign m_info  = m_info_q;
  assign m_id    = m_id_q;
  assign m_valid = m_valid_q;
  assign done    = done_q;
  assign run_id  = run_id_q;
  assign busy    = run_active_q | m_valid_q;

endmodule

// File: tb/tb_dma_arb.sv
// -----------------------------------------------------------------------------
// tb_dma_arb
//
// Table-driven bench for dma_arb with NREQ=4. Each vector record holds the
// inputs for one cycle plus the expected combinational req_ready and the
// expected registered outputs after the following rising edge. A couple of
// hand-written sequences cover reset during a running job.
// -----------------------------------------------------------------------------
module tb_dma_arb;

   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int AW   = 11;
   localparam int IFW  = 8;
   localparam int SZW  = 7;
   localparam int STW  = 5;

   logic                clk;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*AW-1:0]  req_base;
   logic [NREQ*SZW-1:0] req_size;
   logic [NREQ*STW-1:0] req_step;
   logic [NREQ*IFW-1:0] req_info;
   logic [AW-1:0]       m_base;
   logic [SZW-1:0]      m_size;
   logic [STW-1:0]      m_step;
   logic [IFW-1:0]      m_info;
   logic [IDW-1:0]      m_id;
   logic                m_valid;
   logic                m_ready;
   logic                mon_valid;
   logic                mon_ready;
   logic                mon_last;
   logic [NREQ-1:0]     done;
   logic                busy;
   logic [IDW-1:0]      run_id;

   int nCompared;
   int nMismatched;

   typedef struct {
      logic [3:0] reqValid;
      logic       mReady;
      logic       monValid;
      logic       monReady;
      logic       monLast;
      logic       perturb;
      logic [3:0] expReqReady;
      logic       expMValid;
      logic [1:0] expMId;
      logic [3:0] expDone;
      logic       expBusy;
      logic [1:0] expRunId;
   } vec_t;

   vec_t vecs[$];

   dma_arb #(
      .NREQ(NREQ), .IDW(IDW), .AW(AW), .IFW(IFW), .SZW(SZW), .STW(STW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_base(req_base),
      .req_size(req_size),
      .req_step(req_step),
      .req_info(req_info),
      .m_base(m_base),
      .m_size(m_size),
      .m_step(m_step),
      .m_info(m_info),
      .m_id(m_id),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .mon_valid(mon_valid),
      .mon_ready(mon_ready),
      .mon_last(mon_last),
      .done(done),
      .busy(busy),
      .run_id(run_id)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference descriptor fields for each requester (requester 2 gets
   // base 0x100, size 3, step 2)
   function automatic logic [AW-1:0] baseOf(input int i);
      return AW'(32'h0C0 + 32'(i) * 32'h20);
   endfunction
   function automatic logic [SZW-1:0] sizeOf(input int i);
      return SZW'(i + 1);
   endfunction
   function automatic logic [STW-1:0] stepOf(input int i);
      return STW'(i);
   endfunction
   function automatic logic [IFW-1:0] infoOf(input int i);
      return IFW'(32'hA0 + 32'(i));
   endfunction

   function automatic vec_t mk(
      input logic [3:0] rv, input logic mr, input logic mv, input logic mrd,
      input logic ml, input logic pt, input logic [3:0] rdy, input logic emv,
      input logic [1:0] emid, input logic [3:0] edone, input logic ebusy,
      input logic [1:0] erun);
      vec_t v;
      v.reqValid = rv;   v.mReady = mr;     v.monValid = mv;
      v.monReady = mrd;  v.monLast = ml;    v.perturb = pt;
      v.expReqReady = rdy; v.expMValid = emv; v.expMId = emid;
      v.expDone = edone; v.expBusy = ebusy; v.expRunId = erun;
      return v;
   endfunction

   // Single comparison point: bumps the counters and reports a failure line
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive all requester fields; perturb corrupts every field so a capture
   // while stalled would show up as a wrong descriptor
   task automatic applyStimulus(input vec_t v);
      for (int i = 0; i < NREQ; i++) begin
         req_base[i*AW +: AW]   = baseOf(i) ^ (v.perturb ? {AW{1'b1}} : '0);
         req_size[i*SZW +: SZW] = sizeOf(i) ^ (v.perturb ? {SZW{1'b1}} : '0);
         req_step[i*STW +: STW] = stepOf(i) ^ (v.perturb ? {STW{1'b1}} : '0);
         req_info[i*IFW +: IFW] = infoOf(i) ^ (v.perturb ? {IFW{1'b1}} : '0);
      end
      req_valid = v.reqValid;
      m_ready   = v.mReady;
      mon_valid = v.monValid;
      mon_ready = v.monReady;
      mon_last  = v.monLast;
   endtask

   // Registered outputs after the edge; descriptor fields only matter while
   // m_valid is expected high
   task automatic checkOutput(input vec_t v, input string tag);
      check({tag, " m_valid"}, 32'(m_valid), 32'(v.expMValid));
      check({tag, " done"},    32'(done),    32'(v.expDone));
      check({tag, " busy"},    32'(busy),    32'(v.expBusy));
      check({tag, " run_id"},  32'(run_id),  32'(v.expRunId));
      if (v.expMValid) begin
         check({tag, " m_id"},   32'(m_id),   32'(v.expMId));
         check({tag, " m_base"}, 32'(m_base), 32'(baseOf(int'(v.expMId))));
         check({tag, " m_size"}, 32'(m_size), 32'(sizeOf(int'(v.expMId))));
         check({tag, " m_step"}, 32'(m_step), 32'(stepOf(int'(v.expMId))));
         check({tag, " m_info"}, 32'(m_info), 32'(infoOf(int'(v.expMId))));
      end
   endtask

   // One full cycle: drive, check req_ready before the edge, then check
   // registered outputs 1 unit after the edge
   task automatic runVector(input vec_t v, input string tag);
      applyStimulus(v);
      #1;
      check({tag, " req_ready"}, 32'(req_ready), 32'(v.expReqReady));
      @(posedge clk);
      #1;
      checkOutput(v, tag);
   endtask

   initial begin
      vec_t idle;
      nCompared   = 0;
      nMismatched = 0;
      rst_n       = 1'b0;
      idle = mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0);
      applyStimulus(idle);

      // Reset state, with reset still asserted
      #12;
      check("reset m_valid", 32'(m_valid), 32'd0);
      check("reset m_base",  32'(m_base),  32'd0);
      check("reset m_size",  32'(m_size),  32'd0);
      check("reset m_step",  32'(m_step),  32'd0);
      check("reset m_info",  32'(m_info),  32'd0);
      check("reset m_id",    32'(m_id),    32'd0);
      check("reset done",    32'(done),    32'd0);
      check("reset busy",    32'(busy),    32'd0);
      check("reset run_id",  32'(run_id),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

`ifdef DMA_ARB_PRIO_EN
      // Requester 0 wins while valid; then 1..3 round-robin
      //            rv       mr   mv   mrd  ml   pt   rdy      emv  mid   done     bsy  run
      vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 4'b0000, 1'b1, 2'd0));
      vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 4'b0000, 1'b1, 2'd0));
      vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 4'b0000, 1'b1, 2'd0));
      vecs.push_back(mk(4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b1, 2'd0));
      vecs.push_back(mk(4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b1, 2'd1));
      vecs.push_back(mk(4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 4'b0000, 1'b1, 2'd2));
      vecs.push_back(mk(4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b1, 2'd3));
`else
      // Single grant to requester 2, then drain (start makes 2 the owner)
      vecs.push_back(mk(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b1, 2'd0));
      vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b1, 2'd2));
      // All requesting: pointer sits at 3, so order is 3,0,1,2,3,0
      vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 4'b0000, 1'b1, 2'd2));
      vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 4'b0000, 1'b1, 2'd3));
      vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b1, 2'd0));
      vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b1, 2'd1));
      vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 4'b0000, 1'b1, 2'd2));
      vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 4'b0000, 1'b1, 2'd3));
      // Stall five cycles with requester fields scrambled; descriptor must hold
      for (int s = 0; s < 5; s++)
         vecs.push_back(mk(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b1, 2'd3));
      // Release: start of id 0 plus grant of id 1 in the same cycle
      vecs.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b1, 2'd0));
      vecs.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 4'b0000, 1'b1, 2'd0));
      // Job for id 1 starts, id 3 becomes pending
      vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 4'b0000, 1'b1, 2'd1));
      vecs.push_back(mk(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 4'b0000, 1'b1, 2'd1));
      // Ordinary beat, then a last beat without handshake: neither finishes
      vecs.push_back(mk(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 4'b0000, 1'b1, 2'd1));
      vecs.push_back(mk(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3, 4'b0000, 1'b1, 2'd1));
      // Last beat together with start of id 3: done for 1, owner becomes 3
      vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 4'b0010, 1'b1, 2'd3));
      vecs.push_back(mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b1, 2'd3));
      // Last beat of id 3 with nothing pending: done for 3, busy drops
      vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 4'b1000, 1'b0, 2'd3));
      // Stray last beat while idle is ignored
      vecs.push_back(mk(4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 2'd3));
`endif

      foreach (vecs[n]) runVector(vecs[n], $sformatf("v%0d", n));

      // Reset during a running job with a pending descriptor: job for 2
      // starts, then requester 1 is granted and held
      runVector(mk(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b1, run_id), "rj0");
      runVector(mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b1, 2'd2), "rj1");
      runVector(mk(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b1, 2'd2), "rj2");
      applyStimulus(idle);
      #2;
      rst_n = 1'b0;
      #1;
      check("midjob reset m_valid", 32'(m_valid), 32'd0);
      check("midjob reset busy",    32'(busy),    32'd0);
      check("midjob reset done",    32'(done),    32'd0);
      check("midjob reset run_id",  32'(run_id),  32'd0);
      check("midjob reset m_id",    32'(m_id),    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // Stray last beats after reset must not produce done
      runVector(mk(4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0), "pr0");
      runVector(mk(4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0), "pr1");
      // Pointer restarted: requester 0 wins first
      runVector(mk(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 4'b0000, 1'b1, 2'd0), "pr2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   // Safety net so the run always ends
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
